// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared encodings and helpers for the n-way branch target buffer
package btb_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  typedef enum logic {IDLE, FLUSH} flush_state_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == CTR_ST) ? CTR_ST : c + 2'b01;
    else       return (c == CTR_SNT) ? CTR_SNT : c - 2'b01;
  endfunction

endpackage

// File: rtl/btb_plru_tree.sv
// rtl/btb_plru_tree.sv - tree-PLRU victim selection and touch update for one set
module btb_plru_tree #(
  parameter  int WAYS = 4,
  localparam int WAYW = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] bits_i,
  input  logic [WAYW-1:0] touch_way_i,
  output logic [WAYW-1:0] victim_o,
  output logic [WAYS-2:0] bits_o
);

  // Heap layout: level l starts at node 2^l-1; a node bit of 0 sends the victim left.
  always_comb begin
    int node;
    int prefix;
    prefix = 0;
    for (int l = 0; l < WAYW; l++) begin
      node   = (1 << l) - 1 + prefix;
      prefix = prefix * 2 + int'(bits_i[node[WAYW-1:0]]);
    end
    victim_o = prefix[WAYW-1:0];
  end

  always_comb begin
    int node;
    bits_o = bits_i;
    for (int l = 0; l < WAYW; l++) begin
      node = (1 << l) - 1 + (int'(touch_way_i) >> (WAYW - l));
      bits_o[node[WAYW-1:0]] = (((int'(touch_way_i) >> (WAYW - 1 - l)) & 1) == 0);
    end
  end

endmodule

// File: rtl/btb_nway_ctrl.sv
// rtl/btb_nway_ctrl.sv - N-way set-associative BTB with lookup, update/allocate and flush sequencer
module btb_nway_ctrl
  import btb_pkg::*;
#(
  parameter int SETS = 16,
  parameter int WAYS = 4,
  parameter int XLEN = 32,
  parameter int IDXW = $clog2(SETS),
  parameter int TAGW = XLEN - 2 - IDXW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:0]         lu_pc,
  input  logic                    lu_valid,
  output logic                    lu_hit,
  output logic                    lu_taken,
  output logic [XLEN-1:0]         lu_target,
  output logic [$clog2(WAYS)-1:0] lu_way,
  input  logic                    upd_valid,
  input  logic [XLEN-1:0]         upd_pc,
  input  logic                    upd_taken,
  input  logic [XLEN-1:0]         upd_target,
  output logic                    upd_ready,
  input  logic                    flush_req,
  output logic                    busy
);

  localparam int WAYW = $clog2(WAYS);

  logic            valid_q  [SETS][WAYS];
  logic [1:0]      ctr_q    [SETS][WAYS];
  logic [TAGW-1:0] tag_q    [SETS][WAYS];
  logic [XLEN-1:0] target_q [SETS][WAYS];
  logic [WAYS-2:0] plru_q   [SETS];

  flush_state_e    state_q, state_d;
  logic [IDXW-1:0] fcnt_q, fcnt_d;
  logic            flushing;

  logic [IDXW-1:0] lu_idx, upd_idx;
  logic [TAGW-1:0] lu_tag, upd_tag;
  logic            lu_match, upd_match, upd_has_inv;
  logic [WAYW-1:0] lu_w, upd_hit_w, upd_inv_w, upd_victim, upd_wr_way;
  logic [WAYW-1:0] lu_victim_unused;
  logic [WAYS-2:0] lu_plru_new, upd_plru_new;
  logic            lu_touch, upd_fire, upd_touch;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^{lu_pc[1:0], upd_pc[1:0], lu_victim_unused};

  assign flushing  = (state_q == FLUSH);
  assign busy      = flushing;
  assign upd_ready = ~flushing;

  assign lu_idx  = lu_pc[IDXW+1:2];
  assign lu_tag  = lu_pc[XLEN-1:IDXW+2];
  assign upd_idx = upd_pc[IDXW+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDXW+2];

  // Descending scans so that the lowest matching/invalid way wins.
  always_comb begin
    lu_match    = 1'b0;
    lu_w        = '0;
    upd_match   = 1'b0;
    upd_hit_w   = '0;
    upd_has_inv = 1'b0;
    upd_inv_w   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lu_idx][w] && tag_q[lu_idx][w] == lu_tag) begin
        lu_match = 1'b1;
        lu_w     = WAYW'(w);
      end
      if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
        upd_match = 1'b1;
        upd_hit_w = WAYW'(w);
      end
      if (!valid_q[upd_idx][w]) begin
        upd_has_inv = 1'b1;
        upd_inv_w   = WAYW'(w);
      end
    end
  end

  assign lu_hit    = lu_match & ~flushing;
  assign lu_way    = lu_hit ? lu_w : '0;
  assign lu_taken  = lu_hit & ctr_q[lu_idx][lu_w][1];
  assign lu_target = lu_hit ? target_q[lu_idx][lu_w] : '0;

  assign upd_wr_way = upd_match ? upd_hit_w : (upd_has_inv ? upd_inv_w : upd_victim);
  assign upd_fire   = upd_valid & upd_ready;
  assign upd_touch  = upd_fire & (upd_match | upd_taken);
  assign lu_touch   = lu_valid & lu_hit;

  btb_plru_tree #(.WAYS(WAYS)) u_lu_plru (
    .bits_i      (plru_q[lu_idx]),
    .touch_way_i (lu_w),
    .victim_o    (lu_victim_unused),
    .bits_o      (lu_plru_new)
  );

  btb_plru_tree #(.WAYS(WAYS)) u_upd_plru (
    .bits_i      (plru_q[upd_idx]),
    .touch_way_i (upd_wr_way),
    .victim_o    (upd_victim),
    .bits_o      (upd_plru_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == IDXW'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The update touch is written after the lookup touch so it wins on a same-set collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          ctr_q[s][w]   <= CTR_RESET;
        end
      end
    end else if (flushing) begin
      plru_q[fcnt_q] <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[fcnt_q][w] <= 1'b0;
        ctr_q[fcnt_q][w]   <= CTR_RESET;
      end
    end else begin
      if (lu_touch) plru_q[lu_idx] <= lu_plru_new;
      if (upd_touch) begin
        plru_q[upd_idx] <= upd_plru_new;
        if (upd_match) begin
          ctr_q[upd_idx][upd_hit_w] <= ctr_next(ctr_q[upd_idx][upd_hit_w], upd_taken);
        end else begin
          valid_q[upd_idx][upd_wr_way] <= 1'b1;
          ctr_q[upd_idx][upd_wr_way]   <= CTR_ALLOC;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd_touch && upd_taken) begin
      target_q[upd_idx][upd_wr_way] <= upd_target;
      if (!upd_match) tag_q[upd_idx][upd_wr_way] <= upd_tag;
    end
  end

endmodule

// File: tb/tb_btb_nway_ctrl.sv
// tb/tb_btb_nway_ctrl.sv - directed table-driven bench for btb_nway_ctrl
module tb_btb_nway_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lu_pc = '0;
  logic        lu_valid = 1'b0;
  logic        lu_hit, lu_taken;
  logic [31:0] lu_target;
  logic [1:0]  lu_way;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_ready;
  logic        flush_req = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btb_nway_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .lu_pc      (lu_pc),
    .lu_valid   (lu_valid),
    .lu_hit     (lu_hit),
    .lu_taken   (lu_taken),
    .lu_target  (lu_target),
    .lu_way     (lu_way),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_ready  (upd_ready),
    .flush_req  (flush_req),
    .busy       (busy)
  );

  typedef struct {
    bit          is_upd;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    logic        eh;
    logic        et;
    logic [1:0]  ew;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk_u(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    vec_t v;
    v.is_upd = 1'b1; v.pc = pc; v.taken = t; v.tgt = tgt;
    v.eh = 1'b0; v.et = 1'b0; v.ew = 2'd0; v.etgt = 32'h0;
    return v;
  endfunction

  function automatic vec_t mk_l(input logic [31:0] pc, input logic h, input logic t,
                                input logic [1:0] w, input logic [31:0] tgt);
    vec_t v;
    v.is_upd = 1'b0; v.pc = pc; v.taken = 1'b0; v.tgt = 32'h0;
    v.eh = h; v.et = t; v.ew = w; v.etgt = tgt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_lookup(input string nm, input logic [31:0] pc, input logic h,
                              input logic t, input logic [1:0] w, input logic [31:0] tgt);
    lu_pc = pc;
    #1;
    check(nm, 64'({lu_hit, lu_taken, lu_way, lu_target}), 64'({h, t, w, tgt}));
  endtask

  task automatic do_update(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // set 0: allocate, fill, PLRU eviction, counter walk, not-taken miss
    vecs.push_back(mk_l(32'h1000, 0, 0, 0, 32'h0));
    vecs.push_back(mk_u(32'h1000, 1, 32'h2000));
    vecs.push_back(mk_l(32'h1000, 1, 1, 0, 32'h2000));
    vecs.push_back(mk_u(32'h1040, 1, 32'h2040));
    vecs.push_back(mk_u(32'h1080, 1, 32'h2080));
    vecs.push_back(mk_u(32'h10C0, 1, 32'h20C0));
    vecs.push_back(mk_l(32'h10C0, 1, 1, 3, 32'h20C0));
    vecs.push_back(mk_u(32'h1100, 1, 32'h2100));
    vecs.push_back(mk_l(32'h1000, 0, 0, 0, 32'h0));
    vecs.push_back(mk_l(32'h1100, 1, 1, 0, 32'h2100));
    vecs.push_back(mk_u(32'h1000, 1, 32'h3000));
    vecs.push_back(mk_l(32'h1000, 1, 1, 2, 32'h3000));
    vecs.push_back(mk_l(32'h1080, 0, 0, 0, 32'h0));
    vecs.push_back(mk_u(32'h1000, 1, 32'h3000));
    vecs.push_back(mk_u(32'h1000, 1, 32'h3004));
    vecs.push_back(mk_l(32'h1000, 1, 1, 2, 32'h3004));
    vecs.push_back(mk_u(32'h1000, 0, 32'hDEAD));
    vecs.push_back(mk_l(32'h1000, 1, 1, 2, 32'h3004));
    vecs.push_back(mk_u(32'h1000, 0, 32'hDEAD));
    vecs.push_back(mk_l(32'h1000, 1, 0, 2, 32'h3004));
    vecs.push_back(mk_u(32'h1000, 0, 32'hDEAD));
    vecs.push_back(mk_l(32'h1000, 1, 0, 2, 32'h3004));
    vecs.push_back(mk_u(32'h1000, 0, 32'hDEAD));
    vecs.push_back(mk_l(32'h1000, 1, 0, 2, 32'h3004));
    vecs.push_back(mk_u(32'h1000, 1, 32'h3008));
    vecs.push_back(mk_l(32'h1000, 1, 0, 2, 32'h3008));
    vecs.push_back(mk_u(32'h1000, 1, 32'h3008));
    vecs.push_back(mk_l(32'h1000, 1, 1, 2, 32'h3008));
    vecs.push_back(mk_u(32'h3000, 0, 32'h7000));
    vecs.push_back(mk_l(32'h3000, 0, 0, 0, 32'h0));
    vecs.push_back(mk_l(32'h1040, 1, 1, 1, 32'h2040));
    vecs.push_back(mk_l(32'h1004, 0, 0, 0, 32'h0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_upd_ready", 64'(upd_ready), 64'(1));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_upd) do_update(vecs[i].pc, vecs[i].taken, vecs[i].tgt);
      else check_lookup($sformatf("vec%0d", i), vecs[i].pc, vecs[i].eh, vecs[i].et,
                        vecs[i].ew, vecs[i].etgt);
    end

    // set 1: lookup touch steers the victim; same-set collision keeps only the update touch
    do_update(32'h1004, 1, 32'h4000);
    do_update(32'h1044, 1, 32'h4044);
    do_update(32'h1084, 1, 32'h4084);
    do_update(32'h10C4, 1, 32'h40C4);
    lu_pc = 32'h1004; lu_valid = 1'b1;
    @(posedge clk); #1 lu_valid = 1'b0;
    do_update(32'h1104, 1, 32'h4104);
    check_lookup("lu_touch_alloc", 32'h1104, 1, 1, 2, 32'h4104);
    check_lookup("lu_touch_evict", 32'h1084, 0, 0, 0, 32'h0);
    check_lookup("lu_touch_keep", 32'h1004, 1, 1, 0, 32'h4000);
    lu_pc = 32'h1044; lu_valid = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h1104; upd_taken = 1'b1; upd_target = 32'h4108;
    @(posedge clk); #1;
    lu_valid = 1'b0; upd_valid = 1'b0;
    do_update(32'h1204, 1, 32'h4204);
    check_lookup("conflict_alloc", 32'h1204, 1, 1, 1, 32'h4204);
    check_lookup("conflict_evict", 32'h1044, 0, 0, 0, 32'h0);
    check_lookup("conflict_upd", 32'h1104, 1, 1, 2, 32'h4108);

    // flush with a coincident update, a dropped update and an ignored re-request
    upd_valid = 1'b1; upd_pc = 32'h1008; upd_taken = 1'b1; upd_target = 32'h5000;
    flush_req = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0; flush_req = 1'b0;
    check("flush_busy_start", 64'(busy), 64'(1));
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 1) check_lookup("flush_lu_forced_miss", 32'h1040, 0, 0, 0, 32'h0);
      if (upd_ready !== 1'b0) check($sformatf("flush_upd_ready_c%0d", n), 64'(upd_ready), 64'(0));
      upd_valid = (n == 10); upd_pc = 32'h100C; upd_taken = 1'b1; upd_target = 32'h5555;
      flush_req = (n == 3);
      @(posedge clk); #1;
    end
    upd_valid = 1'b0; flush_req = 1'b0;
    check("flush_busy_cycles", 64'(n), 64'(16));
    check("flush_ready_after", 64'(upd_ready), 64'(1));
    check_lookup("post_flush_1000", 32'h1000, 0, 0, 0, 32'h0);
    check_lookup("post_flush_1204", 32'h1204, 0, 0, 0, 32'h0);
    check_lookup("post_flush_1008", 32'h1008, 0, 0, 0, 32'h0);
    check_lookup("post_flush_dropped", 32'h100C, 0, 0, 0, 32'h0);

    // reset in the middle of a flush
    do_update(32'h1028, 1, 32'h6000);
    check_lookup("pre_rst_hit", 32'h1028, 1, 1, 0, 32'h6000);
    flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_flush_busy", 64'(busy), 64'(0));
    check("rst_mid_flush_ready", 64'(upd_ready), 64'(1));
    @(posedge clk); #1 rst = 1'b0;
    check_lookup("rst_cleared", 32'h1028, 0, 0, 0, 32'h0);
    do_update(32'h1028, 1, 32'h6004);
    check_lookup("rst_realloc", 32'h1028, 1, 1, 0, 32'h6004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_nway_ctrl.md
Name: btb_nway_ctrl

Overview:
- Parametrised N-way set-associative branch target buffer with integrated lookup, update and allocation logic.
- Successor to the fixed 8-set/2-way BTB storage; adds tree-PLRU replacement, 2-bit counter read-modify-write, allocate-on-taken-miss, and a multi-cycle flush sequencer.
- Lookup is zero-cycle combinational for the fetch stage. The update port is fed from branch resolution in EX.

Parameters:
- SETS, 16, number of sets; power of two, >= 2.
- WAYS, 4, associativity; power of two, >= 2.
- XLEN, 32, PC/target width.
- IDXW, $clog2(SETS), set index width (derived).
- TAGW, XLEN-2-IDXW, tag width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- lu_pc  in  XLEN  fetch PC to look up
- lu_valid  in  1  lookup qualifier; a hit refreshes PLRU
- lu_hit  out  1  valid tag match (combinational)
- lu_taken  out  1  predicted taken = counter MSB of hit way; 0 on miss
- lu_target  out  XLEN  target of hit way; 0 on miss
- lu_way  out  $clog2(WAYS)  hit way index; 0 on miss
- upd_valid  in  1  resolved-branch update strobe
- upd_pc  in  XLEN  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual target
- upd_ready  out  1  0 while flushing; updates with upd_ready=0 are dropped
- flush_req  in  1  single-cycle pulse: invalidate the whole BTB
- busy  out  1  high during flush

Behaviour:
- Address split: index = pc[IDXW+1:2]; tag = pc[XLEN-1:IDXW+2].
- Storage per set/way: valid, tag, target, 2-bit counter. Per set: WAYS-1 tree-PLRU bits.
- Reset:
  - all valid=0, counters=2'b01, PLRU bits=0, FSM=IDLE.
  - Outputs: lu_hit=0, lu_taken=0, lu_target=0, lu_way=0, busy=0, upd_ready=1.
- Lookup: purely combinational from the arrays, no added latency.
  - Duplicate tag match (illegal): lowest way wins.
  - Lookup never sees the same-cycle update; new contents are visible the next cycle.
- Update (registered at posedge, when upd_valid & upd_ready):
  - Hit, taken: counter saturating +1 (max 11); target <= upd_target; PLRU touch.
  - Hit, not taken: counter saturating -1 (min 00); target unchanged; PLRU touch.
  - Miss, taken: allocate. Way = lowest invalid way, else PLRU victim. Write valid=1, tag, target, counter=2'b10; PLRU touch.
  - Miss, not taken: no write.
- PLRU convention:
  - node bit 0 = victim on left subtree.
  - touch(w) sets every node on w's path to point away from w.
  - Heap layout: node 0 = root; children of node n are 2n+1 and 2n+2.
- PLRU conflicts:
  - lu_valid hit and an update in the same set, same cycle: update's touch wins and the lookup touch is discarded.
  - Different sets: both apply.
- Flush FSM: IDLE -> FLUSH on flush_req.
  - In FLUSH, one set per cycle (counter 0..SETS-1): valid=0, counter=01, PLRU=0.
  - FLUSH -> IDLE after set SETS-1, so busy is high for exactly SETS cycles, starting the cycle after flush_req.
- During FLUSH:
  - lu_hit forced 0 and no lookup touch.
  - upd_ready=0.
  - flush_req ignored.
- Reset mid-flush returns to IDLE with all arrays cleared.
- flush_req and upd_valid in the same IDLE cycle: the update commits, then the flush starts.

Decomposition:
- Shared package btb_pkg:
  - counter encodings: SNT=00, WNT=01, WT=10, ST=11
  - reset counter value WNT; allocate counter value WT
  - flush FSM state enum {IDLE, FLUSH}
- Sub-module btb_plru_tree: parametrised by WAYS; combinational victim(bits) and touch(bits, way) -> new bits. Instantiated once for the lookup path and once for the update path.

Test Plan:
(All cases use defaults SETS=16, WAYS=4.)
- Post-reset lookup of 0x0000_1000 -> lu_hit=0, lu_target=0, lu_taken=0, busy=0.
- Update pc=0x1000, taken, target=0x2000 -> next cycle lookup 0x1000 gives lu_hit=1, lu_way=0, lu_target=0x2000, lu_taken=1 (counter 10).
- Fill set 0 with taken updates to 0x1000, 0x1040, 0x1080, 0x10C0 (ways 0..3). Then taken update to 0x1100 -> evicts way 0: lookup 0x1000 misses, lookup 0x1100 hits with lu_way=0.
- Counter walk on 0x1000 (allocated 10):
  - taken, taken -> counter saturates at 11.
  - then not-taken x3 -> lu_taken=0, lu_hit=1, counter 00.
  - another not-taken -> stays 00.
- Not-taken update to an absent pc 0x3000 -> no allocation; lookup 0x3000 misses.
- flush_req with valid entries present:
  - busy high exactly 16 cycles; upd_ready=0 throughout; an update presented during flush is dropped.
  - afterwards all lookups miss.
  - rst asserted at flush cycle 5 -> busy=0 immediately.
